// File: rtl/ex_pkg.sv
// ex_pkg: shared width, R-type funct codes and execute-stage FSM states
package ex_pkg;
  localparam int W = 32;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  typedef enum logic {IDLE, MUL} ex_state_t;
endpackage

// File: rtl/ex_if.sv
// ex_if: upstream handshake/operands and EX/MEM writeback bundle of the execute stage
interface ex_if;
  import ex_pkg::*;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   funct;
  logic [W-1:0] readData1;
  logic [W-1:0] readData2;
  logic [4:0]   wr_reg_in;
  logic         out_valid;
  logic [W-1:0] result;
  logic [4:0]   wr_reg_out;
  logic         regWrite;
  logic         zero;
  modport master (
    output in_valid, funct, readData1, readData2, wr_reg_in,
    input  in_ready, out_valid, result, wr_reg_out, regWrite, zero
  );
  modport slave (
    input  in_valid, funct, readData1, readData2, wr_reg_in,
    output in_ready, out_valid, result, wr_reg_out, regWrite, zero
  );
endinterface

// File: rtl/ex_mult_iter.sv
// ex_mult_iter: shift-add unsigned multiplier, one multiplier bit per cycle, product doubles as {HI,LO}
module ex_mult_iter import ex_pkg::*; #(
  parameter int N = W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W:0]    sum;
  assign sum = {1'b0, product[2*W-1:W]} + (product[0] ? {1'b0, a_q} : '0);
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  // multiplier sits in the low half and shifts out as partial sums shift in on top
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      a_q <= '0;
      product <= '0;
    end else if (start) begin
      cnt <= CW'(N);
      a_q <= a;
      product <= {{W{1'b0}}, b};
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      product <= {sum, product[W-1:1]};
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: R-type ALU execute stage with EX/MEM result register; EX_MULT_EN adds MULTU and HI/LO
module ex_stage import ex_pkg::*; #(
  parameter int MUL_LAT = W
) (
  input logic clk,
  input logic rst,
  ex_if.slave io
);
  logic         accept, issue, mul_start, mul_done, alu_wr;
  logic [W-1:0] alu_res;
`ifdef EX_MULT_EN
  ex_state_t      state, state_nx;
  logic           mul_busy;
  logic [2*W-1:0] prod;
  logic [W-1:0]   hi, lo;
  assign hi = prod[2*W-1:W];
  assign lo = prod[W-1:0];
  assign mul_start = accept & (io.funct == FUNCT_MULTU);
  assign io.in_ready = (state == IDLE) & ~mul_busy & ~rst;
  ex_mult_iter #(.N(MUL_LAT)) u_mult (
    .clk,
    .rst,
    .start(mul_start),
    .a(io.readData1),
    .b(io.readData2),
    .busy(mul_busy),
    .done(mul_done),
    .product(prod)
  );
  // FSM state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // stall upstream from MULTU accept until the last multiplier iteration
  always_comb begin
    state_nx = mul_start ? MUL : (mul_done ? IDLE : state);
  end
`else
  assign mul_start = 1'b0;
  assign mul_done = 1'b0;
  assign io.in_ready = ~rst;
`endif
  assign accept = io.in_valid & io.in_ready;
  assign issue = accept & ~mul_start;
  // funct decode; unknown codes become a no-op slot with result 0 and no write
  always_comb begin
    alu_res = '0;
    alu_wr = 1'b1;
    case (io.funct)
      FUNCT_ADD, FUNCT_ADDU: alu_res = io.readData1 + io.readData2;
      FUNCT_SUB, FUNCT_SUBU: alu_res = io.readData1 - io.readData2;
      FUNCT_AND:             alu_res = io.readData1 & io.readData2;
      FUNCT_OR:              alu_res = io.readData1 | io.readData2;
      FUNCT_XOR:             alu_res = io.readData1 ^ io.readData2;
      FUNCT_NOR:             alu_res = ~(io.readData1 | io.readData2);
      FUNCT_SLT:             alu_res = W'($signed(io.readData1) < $signed(io.readData2));
      FUNCT_SLTU:            alu_res = W'(io.readData1 < io.readData2);
`ifdef EX_MULT_EN
      FUNCT_MFHI:            alu_res = hi;
      FUNCT_MFLO:            alu_res = lo;
`endif
      default:               alu_wr = 1'b0;
    endcase
  end
  // EX/MEM register: one valid pulse per issued op or multiply completion, data holds otherwise
  always_ff @(posedge clk)
    if (rst) begin
      io.out_valid <= 1'b0;
      io.result <= '0;
      io.wr_reg_out <= '0;
      io.regWrite <= 1'b0;
      io.zero <= 1'b0;
    end else begin
      io.out_valid <= issue | mul_done;
      io.regWrite <= issue & alu_wr;
      if (issue) begin
        io.result <= alu_res;
        io.zero <= ~|alu_res;
        io.wr_reg_out <= io.wr_reg_in;
      end else if (mul_done) begin
        io.result <= '0;
        io.zero <= 1'b1;
      end
    end
endmodule
